// File: rtl/pipe_hazard_sched.sv
// ---------------------------------------------------------------------------
// pipe_hazard_sched
// Pipeline control scheduler for a 5-stage MIPS CPU.
//
// The block does three jobs:
//   - It resolves load-use hazards and taken branches/jumps into PC write,
//     IF/ID write, IF/ID flush and ID/EX bubble controls.
//   - It sequences a multi-cycle data-memory access with a req/ack handshake.
//     The whole pipeline is frozen from the launch cycle until the ack (or a
//     timeout). It is then released for one DONE cycle so MEM can advance.
//   - Optionally, it keeps saturating stall/flush performance counters.
//
// Optional feature macro: PIPE_HAZARD_PERF_CNT_EN
//   defined   : stall_cnt_o / flush_cnt_o count stall and flush cycles.
//   undefined : no counter flops, and both counter ports read as zero.
//
// Parameters:
//   MEM_TIMEOUT : maximum ACCESS cycles spent waiting for mem_ack_i (2..255).
//   CNT_W       : width of the performance counters.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               run enable; low holds the pipeline and all state
//   idex_memread_i        ID/EX holds a load
//   idex_rt_i             destination register of that load
//   ifid_rs_i, ifid_rt_i  source fields of the instruction in IF/ID
//   branch_taken_i        branch resolved taken in ID
//   jump_i                jump decoded in ID
//   mem_req_i             EX/MEM instruction accesses data memory
//   mem_ack_i             data memory access complete
//   mem_start_o           one-cycle access launch pulse
//   pc_write_o            PC write enable
//   ifid_write_o          IF/ID write enable
//   ifid_flush_o          zero the IF/ID instruction
//   idex_bubble_o         insert a nop into ID/EX
//   pipe_freeze_o         hold all pipeline registers and the PC
//   err_o                 sticky memory-timeout flag (cleared only by reset)
//   stall_cnt_o           stall cycle count
//   flush_cnt_o           flush cycle count
// ---------------------------------------------------------------------------
module pipe_hazard_sched #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             mem_start_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_freeze_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Last ACCESS cycle before a forced release.
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       err_q, err_d;
    logic       load_use_s;

    // Load-use hazard: a load in ID/EX writes a register read by IF/ID ($0 never hazards).
    always_comb begin
        load_use_s = idex_memread_i & (idex_rt_i != 5'd0) &
                     ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));
    end

    // Next-state logic for the memory-access sequencer and its timeout counter.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        err_d   = err_q;
        if (start_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_req_i) begin
                        state_d = ST_ACCESS;
                        tcnt_d  = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // An ack in the final cycle wins over the timeout.
                    if (mem_ack_i) begin
                        state_d = ST_DONE;
                        tcnt_d  = 8'd0;
                    end else if (tcnt_q == TO_LAST) begin
                        state_d = ST_DONE;
                        tcnt_d  = 8'd0;
                        err_d   = 1'b1;
                    end else begin
                        tcnt_d  = tcnt_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    // The request still visible in DONE is the one just
                    // served, so it is deliberately ignored here.
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    tcnt_d  = 8'd0;
                end
            endcase
        end else begin
            // Run enable low: everything holds.
            state_d = state_q;
            tcnt_d  = tcnt_q;
            err_d   = err_q;
        end
    end

    // Sequencer state, timeout counter and sticky error register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            tcnt_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
        end
    end

    // Pipeline controls in priority order: freeze, load-use, branch/jump, normal.
    always_comb begin
        mem_start_o   = 1'b0;
        pipe_freeze_o = 1'b0;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        if (rst_i || !start_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else begin
            mem_start_o   = (state_q == ST_IDLE) & mem_req_i;
            pipe_freeze_o = ((state_q == ST_IDLE) & mem_req_i) | (state_q == ST_ACCESS);
            if (pipe_freeze_o) begin
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
            end else if (load_use_s) begin
                // The branch, if any, is re-evaluated once the load clears.
                idex_bubble_o = 1'b1;
            end else if (branch_taken_i | jump_i) begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                ifid_flush_o = 1'b1;
            end else begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
            end
        end
    end

    assign err_o = err_q;

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    // Saturating counter increments; counters stop at all-ones instead of wrapping.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (start_i && (pipe_freeze_o || load_use_s) && !(&stall_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
        if (ifid_flush_o && !(&flush_q)) begin
            flush_d = flush_q + CNT_W'(1);
        end else begin
            flush_d = flush_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_sched
// Each test task sets up the inputs for one cycle and calls cycle(). That
// call computes the expected outputs from an independent reference model and
// pushes them to a scoreboard queue. The negedge monitor pops each entry and
// compares it with the DUT. The test tasks also make their own directed
// checks against fixed constants: pulse counts, freeze lengths and the
// sticky error flag.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_sched;

    localparam int T  = 16;
    localparam int CW = 32;
`ifdef PIPE_HAZARD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_i, start_i, idex_memread_i, branch_taken_i, jump_i;
    logic          mem_req_i, mem_ack_i;
    logic [4:0]    idex_rt_i, ifid_rs_i, ifid_rt_i;
    logic          mem_start_o, pc_write_o, ifid_write_o, ifid_flush_o;
    logic          idex_bubble_o, pipe_freeze_o, err_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    always #5 clk = ~clk;

    pipe_hazard_sched #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
        .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
        .branch_taken_i(branch_taken_i), .jump_i(jump_i),
        .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
        .mem_start_o(mem_start_o), .pc_write_o(pc_write_o),
        .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
        .idex_bubble_o(idex_bubble_o), .pipe_freeze_o(pipe_freeze_o),
        .err_o(err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    typedef struct {
        string         tag;
        logic [6:0]    ctl;    // {ms, frz, pcw, ifw, fl, bub, err}
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        bit            known;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int            m_st = 0;      // 0 idle, 1 access, 2 done
    int            m_tcnt = 0;
    bit            m_err = 1'b0;
    logic [CW-1:0] m_stall = '0;
    logic [CW-1:0] m_flush = '0;
    bit            m_known = 1'b0;

    // One clock cycle with the current inputs: predict, enqueue, advance model.
    task automatic cycle(input string tag);
        exp_t e;
        bit lu, launch, frz, ms, pcw, ifw, fl, bub;
        lu = idex_memread_i && (idex_rt_i != 5'd0) &&
             ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
        launch = 1'b0; frz = 1'b0; ms = 1'b0; pcw = 1'b0; ifw = 1'b0; fl = 1'b0; bub = 1'b0;
        if (!rst_i && start_i) begin
            launch = (m_st == 0) && mem_req_i;
            frz    = launch || (m_st == 1);
            ms     = launch;
            if (frz) begin
                pcw = 1'b0;
            end else if (lu) begin
                bub = 1'b1;
            end else if (branch_taken_i || jump_i) begin
                pcw = 1'b1; ifw = 1'b1; fl = 1'b1;
            end else begin
                pcw = 1'b1; ifw = 1'b1;
            end
        end
        e.tag   = tag;
        e.ctl   = {ms, frz, pcw, ifw, fl, bub, m_err};
        e.sc    = m_stall;
        e.fc    = m_flush;
        e.known = m_known;
        q.push_back(e);
        @(posedge clk);
        if (rst_i) begin
            m_st = 0; m_tcnt = 0; m_err = 1'b0; m_stall = '0; m_flush = '0; m_known = 1'b1;
        end else if (start_i) begin
            if (PERF == 1 && (frz || lu) && m_stall != '1) m_stall = m_stall + 1;
            if (PERF == 1 && fl && m_flush != '1) m_flush = m_flush + 1;
            case (m_st)
                0: if (mem_req_i) begin m_st = 1; m_tcnt = 0; end
                1: begin
                    if (mem_ack_i) begin
                        m_st = 2; m_tcnt = 0;
                    end else if (m_tcnt == T - 1) begin
                        m_st = 2; m_tcnt = 0; m_err = 1'b1;
                    end else begin
                        m_tcnt = m_tcnt + 1;
                    end
                end
                default: m_st = 0;
            endcase
        end
        #1;
    endtask

    // Scoreboard monitor: compare the DUT mid-cycle against the oldest prediction.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [6:0] act;
            e   = q.pop_front();
            act = {mem_start_o, pipe_freeze_o, pc_write_o, ifid_write_o,
                   ifid_flush_o, idex_bubble_o, err_o};
            checks++;
            if (act !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl {ms,frz,pcw,ifw,fl,bub,err}: got %b expected %b",
                         e.tag, act, e.ctl);
            end
            if (e.known) begin
                checks++;
                if (stall_cnt_o !== e.sc || flush_cnt_o !== e.fc) begin
                    errors++;
                    $display("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                             e.tag, stall_cnt_o, flush_cnt_o, e.sc, e.fc);
                end
            end
        end
    end

    task automatic idle_inputs();
        rst_i = 1'b0; start_i = 1'b1; idex_memread_i = 1'b0; idex_rt_i = 5'd0;
        ifid_rs_i = 5'd1; ifid_rt_i = 5'd2; branch_taken_i = 1'b0; jump_i = 1'b0;
        mem_req_i = 1'b0; mem_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        cycle("reset0");
        #1;
        checks++;
        if (pc_write_o !== 1'b0 || ifid_write_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_forced pcw/ifw: got %b%b expected 00", pc_write_o, ifid_write_o);
        end
        cycle("reset1");
        rst_i = 1'b0;
        #1;
        checks++;
        if (pc_write_o !== 1'b1 || ifid_write_o !== 1'b1 || err_o !== 1'b0 ||
            stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got pcw=%b ifw=%b err=%b sc=%0d fc=%0d expected 1 1 0 0 0",
                     pc_write_o, ifid_write_o, err_o, stall_cnt_o, flush_cnt_o);
        end
        cycle("idle0");
        cycle("idle1");
    endtask

    task automatic test_load_use();
        idex_memread_i = 1'b1; idex_rt_i = 5'd8; ifid_rs_i = 5'd8;
        #1;
        checks++;
        if (pc_write_o !== 1'b0 || idex_bubble_o !== 1'b1) begin
            errors++;
            $display("FAIL load_use: got pcw=%b bub=%b expected 0 1", pc_write_o, idex_bubble_o);
        end
        cycle("load_use_rs");
        idex_rt_i = 5'd0; ifid_rs_i = 5'd0;
        #1;
        checks++;
        if (stall_cnt_o !== 32'(PERF) || idex_bubble_o !== 1'b0) begin
            errors++;
            $display("FAIL load_use_r0: got sc=%0d bub=%b expected %0d 0", stall_cnt_o, idex_bubble_o, PERF);
        end
        cycle("load_use_r0");
        idex_rt_i = 5'd9; ifid_rs_i = 5'd3; ifid_rt_i = 5'd9;
        cycle("load_use_rt");
        idle_inputs();
        cycle("after_lu");
    endtask

    task automatic test_branch();
        branch_taken_i = 1'b1;
        #1;
        checks++;
        if (ifid_flush_o !== 1'b1 || pc_write_o !== 1'b1) begin
            errors++;
            $display("FAIL branch_flush: got fl=%b pcw=%b expected 1 1", ifid_flush_o, pc_write_o);
        end
        cycle("branch");
        branch_taken_i = 1'b0; jump_i = 1'b1;
        cycle("jump");
        idex_memread_i = 1'b1; idex_rt_i = 5'd4; ifid_rs_i = 5'd4;
        #1;
        checks++;
        if (ifid_flush_o !== 1'b0 || idex_bubble_o !== 1'b1 || flush_cnt_o !== 32'(2 * PERF)) begin
            errors++;
            $display("FAIL branch_with_lu: got fl=%b bub=%b fc=%0d expected 0 1 %0d",
                     ifid_flush_o, idex_bubble_o, flush_cnt_o, 2 * PERF);
        end
        cycle("jump_lu");
        idle_inputs();
        cycle("after_br");
    endtask

    task automatic test_mem_access();
        int frz_n = 0;
        int ms_n  = 0;
        mem_req_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mem_ack_i = (k == 3);
            branch_taken_i = (k == 4);   // served in DONE, freeze released
            #1;
            if (pipe_freeze_o === 1'b1) frz_n++;
            if (mem_start_o === 1'b1) ms_n++;
            cycle($sformatf("mem_k%0d", k));
        end
        idle_inputs();
        checks++;
        if (frz_n !== 4 || ms_n !== 1) begin
            errors++;
            $display("FAIL mem_access: got freeze=%0d starts=%0d expected 4 1", frz_n, ms_n);
        end
        mem_ack_i = 1'b1;                // stray ack in IDLE is ignored
        cycle("stray_ack");
        idle_inputs();
        start_i = 1'b0; mem_req_i = 1'b1;
        cycle("start_low");
        idle_inputs();
    endtask

    task automatic test_timeout();
        int frz_n = 0;
        mem_req_i = 1'b1;
        #1;
        if (pipe_freeze_o === 1'b1) frz_n++;
        cycle("to_launch");
        mem_req_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (pipe_freeze_o !== 1'b1) break;
            frz_n++;
            cycle($sformatf("to_acc%0d", k));
        end
        checks++;
        if (frz_n !== T + 1) begin
            errors++;
            $display("FAIL timeout_len: got freeze=%0d expected %0d", frz_n, T + 1);
        end
        for (int k = 0; k < 3; k++) cycle($sformatf("to_after%0d", k));
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", err_o);
        end
    endtask

    task automatic test_reset_mid_access();
        mem_req_i = 1'b1;
        cycle("rm_launch");
        cycle("rm_acc1");
        rst_i = 1'b1;
        cycle("rm_acc2_rst");
        idle_inputs();
        #1;
        checks++;
        if (pipe_freeze_o !== 1'b0 || mem_start_o !== 1'b0 || err_o !== 1'b0 ||
            stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_access: got frz=%b ms=%b err=%b sc=%0d fc=%0d expected 0 0 0 0 0",
                     pipe_freeze_o, mem_start_o, err_o, stall_cnt_o, flush_cnt_o);
        end
        cycle("rm_after");
        cycle("rm_idle");
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_access();
        test_timeout();
        test_reset_mid_access();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
